// File: rtl/chipper_inject_ctrl.sv
// CHIPPER PE injection controller: FIFO, inject handshake, loopback, golden epoch.
// Optional starvation monitor enabled by defining CHIPPER_STARVE_MON_EN.
module chipper_inject_ctrl #(
  parameter logic [1:0] X_COORD      = 2'b01,
  parameter logic [1:0] Y_COORD      = 2'b01,
  parameter logic [1:0] Z_COORD      = 2'b01,
  parameter int         DEPTH        = 4,
  parameter int         BURST_MAX    = 4,
  parameter int         EPOCH_LEN    = 64,
  parameter int         STARVE_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pe_valid,
  input  logic [31:0] pe_flit,
  output logic        pe_ready,
  output logic        inject_request,
  input  logic        inject_grant,
  output logic [31:0] pein_flit,
  output logic        lb_valid,
  output logic [31:0] lb_flit,
  input  logic        lb_ready,
  output logic [5:0]  golden_id,
  output logic        golden_tick,
  output logic        starve_alarm
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int EW = $clog2(EPOCH_LEN);
  localparam logic [5:0] SELF_ID = {X_COORD, Y_COORD, Z_COORD};
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
  localparam logic [EW-1:0] EPOCH_LAST = EW'(EPOCH_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    LOOP,
    GAP
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   rem;
  logic [BW-1:0]   burst_q, burst_d;
  logic            req_q, req_d;
  logic            lbv_q, lbv_d;
  logic [31:0]     pein_q, pein_d;
  logic [31:0]     lbf_q, lbf_d;
  logic [EW-1:0]   epoch_q, epoch_d;
  logic [5:0]      gid_q, gid_d;
  logic            tick_q, tick_d;
  logic            push, pop;
  logic            nh_valid;
  logic [31:0]     nh;
  state_e          sel_state;

  assign pe_ready       = (count_q != FULL_CNT);
  assign inject_request = req_q;
  assign pein_flit      = pein_q;
  assign lb_valid       = lbv_q;
  assign lb_flit        = lbf_q;
  assign golden_id      = gid_q;
  assign golden_tick    = tick_q;

  // FIFO bookkeeping and the head that will be presented next cycle
  always_comb begin
    push     = pe_valid && pe_ready;
    pop      = ((state_q == REQ) && inject_grant)
            || ((state_q == LOOP) && lb_ready);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    rem      = count_q - CW'(pop);
    nh_valid = 1'b0;
    nh       = '0;
    if (rem != '0) begin
      nh_valid = 1'b1;
      nh       = mem_q[rd_ptr_d];
    end else if (push) begin
      nh_valid = 1'b1;
      nh       = pe_flit;
    end
    if (!nh_valid) begin
      sel_state = IDLE;
    end else if (nh[31:26] == SELF_ID) begin
      sel_state = LOOP;
    end else begin
      sel_state = REQ;
    end
  end

  // Next-state, burst counter and next registered outputs
  always_comb begin
    state_d = state_q;
    burst_d = '0;
    unique case (state_q)
      IDLE: state_d = sel_state;
      REQ: begin
        if (inject_grant) begin
          if (burst_q == BURST_LAST) begin
            state_d = GAP;
          end else begin
            state_d = sel_state;
          end
        end
      end
      LOOP: begin
        if (lb_ready) begin
          state_d = sel_state;
        end
      end
      GAP: state_d = sel_state;
    endcase
    if ((state_q == REQ) && inject_grant
        && (state_d == REQ)) begin
      burst_d = burst_q + 1'b1;
    end
    req_d  = (state_d == REQ);
    lbv_d  = (state_d == LOOP);
    pein_d = (state_d == REQ) ? nh : '0;
    lbf_d  = (state_d == LOOP) ? nh : '0;
  end

  // Golden epoch counter and id advance
  always_comb begin
    if (epoch_q == EPOCH_LAST) begin
      epoch_d = '0;
      gid_d   = gid_q + 1'b1;
    end else begin
      epoch_d = epoch_q + 1'b1;
      gid_d   = gid_q;
    end
    tick_d = (epoch_d == EPOCH_LAST);
  end

  // FSM state and its registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      burst_q <= '0;
      req_q   <= 1'b0;
      lbv_q   <= 1'b0;
      pein_q  <= '0;
      lbf_q   <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      req_q   <= req_d;
      lbv_q   <= lbv_d;
      pein_q  <= pein_d;
      lbf_q   <= lbf_d;
    end
  end

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= pe_flit;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Free-running golden epoch registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epoch_q <= '0;
      gid_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      epoch_q <= epoch_d;
      gid_q   <= gid_d;
      tick_q  <= tick_d;
    end
  end

`ifdef CHIPPER_STARVE_MON_EN
  localparam logic [4:0] STARVE_LIM = 5'(STARVE_LIMIT);

  logic [4:0] starve_q, starve_d;
  logic       alarm_q, alarm_d;

  // Saturating count of ungranted request cycles
  always_comb begin
    starve_d = '0;
    if ((state_q == REQ) && !inject_grant) begin
      starve_d = (starve_q == 5'h1f) ? starve_q : starve_q + 1'b1;
    end
    alarm_d = (starve_d >= STARVE_LIM);
  end

  // Starvation counter and alarm registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      alarm_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      alarm_q  <= alarm_d;
    end
  end

  assign starve_alarm = alarm_q;
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT == 0);
  assign starve_alarm = 1'b0;
`endif

endmodule

// File: tb/tb_chipper_inject_ctrl.sv
// Directed self-checking bench for chipper_inject_ctrl.
// Each task drives one scenario and checks outputs against hand-derived values.
module tb_chipper_inject_ctrl;

  logic        clk;
  logic        rst_n;
  logic        pe_valid;
  logic [31:0] pe_flit;
  logic        pe_ready;
  logic        inject_request;
  logic        inject_grant;
  logic [31:0] pein_flit;
  logic        lb_valid;
  logic [31:0] lb_flit;
  logic        lb_ready;
  logic [5:0]  golden_id;
  logic        golden_tick;
  logic        starve_alarm;

  int n_cmp;
  int n_bad;

  chipper_inject_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .pe_valid(pe_valid),
    .pe_flit(pe_flit),
    .pe_ready(pe_ready),
    .inject_request(inject_request),
    .inject_grant(inject_grant),
    .pein_flit(pein_flit),
    .lb_valid(lb_valid),
    .lb_flit(lb_flit),
    .lb_ready(lb_ready),
    .golden_id(golden_id),
    .golden_tick(golden_tick),
    .starve_alarm(starve_alarm)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n        = 1'b0;
    pe_valid     = 1'b0;
    pe_flit      = '0;
    inject_grant = 1'b0;
    lb_ready     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic       exp_tick;
    logic [5:0] exp_id;
    do_reset();
    #1;
    n_cmp++;
    if (pe_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_pe_ready: got %b want 1", pe_ready);
    end
    n_cmp++;
    if ({inject_request, lb_valid, golden_tick, starve_alarm} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b%b%b%b want 0000",
               inject_request, lb_valid, golden_tick, starve_alarm);
    end
    n_cmp++;
    if ({pein_flit, lb_flit, golden_id} !== 70'h0) begin
      n_bad++;
      $display("FAIL reset_data: pein %h lb %h id %h want 0",
               pein_flit, lb_flit, golden_id);
    end
    for (int n = 1; n <= 130; n++) begin
      @(posedge clk);
      #1;
      exp_tick = ((n % 64) == 63);
      exp_id   = 6'(n / 64);
      n_cmp++;
      if (golden_tick !== exp_tick) begin
        n_bad++;
        $display("FAIL epoch_tick c%0d: got %b want %b", n, golden_tick, exp_tick);
      end
      n_cmp++;
      if (golden_id !== exp_id) begin
        n_bad++;
        $display("FAIL epoch_id c%0d: got %0d want %0d", n, golden_id, exp_id);
      end
    end
    n_cmp++;
    if ({inject_request, lb_valid, pe_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL idle_outputs: got %b%b%b want 001",
               inject_request, lb_valid, pe_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    inject_grant = 1'b1;
    pe_valid     = 1'b1;
    pe_flit      = 32'h50FF_FFFC;
    #1;
    n_cmp++;
    if (inject_request !== 1'b0) begin
      n_bad++;
      $display("FAIL single_no_bypass: got %b want 0", inject_request);
    end
    @(posedge clk);
    #1;
    pe_valid = 1'b0;
    n_cmp++;
    if (inject_request !== 1'b1 || pein_flit !== 32'h50FF_FFFC) begin
      n_bad++;
      $display("FAIL single_req: req %b flit %h want 1 50fffffc",
               inject_request, pein_flit);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (inject_request !== 1'b0 || pein_flit !== 32'h0 || pe_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL single_empty: req %b flit %h rdy %b want 0 0 1",
               inject_request, pein_flit, pe_ready);
    end
    inject_grant = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] f [4];
    f[0] = 32'h0000_0A00;
    f[1] = 32'h0000_0A01;
    f[2] = 32'h0000_0A02;
    f[3] = 32'h0000_0A03;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pe_valid = 1'b1;
      pe_flit  = f[i];
      @(posedge clk);
      #1;
      n_cmp++;
      if (pe_ready !== (i < 3)) begin
        n_bad++;
        $display("FAIL bp_ready push%0d: got %b want %b", i, pe_ready, (i < 3));
      end
    end
    pe_flit = 32'h0000_0BAD;
    @(posedge clk);
    #1;
    pe_valid = 1'b0;
    n_cmp++;
    if (pe_ready !== 1'b0 || inject_request !== 1'b1 || pein_flit !== f[0]) begin
      n_bad++;
      $display("FAIL bp_full_hold: rdy %b req %b flit %h want 0 1 %h",
               pe_ready, inject_request, pein_flit, f[0]);
    end
    inject_grant = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (inject_request !== 1'b1 || pein_flit !== f[i] || pe_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_drain%0d: req %b flit %h rdy %b want 1 %h 1",
                 i, inject_request, pein_flit, pe_ready, f[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (inject_request !== 1'b0 || pein_flit !== 32'h0) begin
        n_bad++;
        $display("FAIL bp_after%0d: req %b flit %h want 0 0",
                 i, inject_request, pein_flit);
      end
    end
    inject_grant = 1'b0;
  endtask

  task automatic test_burst();
    logic [31:0] exp_flit [8];
    logic        exp_req  [8];
    exp_req  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_flit = '{32'h0000_1000, 32'h0000_1001, 32'h0000_1002,
                 32'h0000_1003, 32'h0,          32'h0000_1004,
                 32'h0000_1005, 32'h0};
    do_reset();
    inject_grant = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pe_valid = (k < 6);
      pe_flit  = 32'h0000_1000 + 32'(k);
      @(posedge clk);
      #1;
      n_cmp++;
      if (inject_request !== exp_req[k] || pein_flit !== exp_flit[k]) begin
        n_bad++;
        $display("FAIL burst_c%0d: req %b flit %h want %b %h",
                 k, inject_request, pein_flit, exp_req[k], exp_flit[k]);
      end
    end
    pe_valid     = 1'b0;
    inject_grant = 1'b0;
  endtask

  task automatic test_loopback();
    do_reset();
    pe_valid = 1'b1;
    pe_flit  = 32'h54FF_FFF8;
    @(posedge clk);
    #1;
    pe_flit = 32'hB000_0000;
    n_cmp++;
    if (lb_valid !== 1'b1 || lb_flit !== 32'h54FF_FFF8
        || inject_request !== 1'b0 || pein_flit !== 32'h0) begin
      n_bad++;
      $display("FAIL lb_enter: v %b flit %h req %b pein %h want 1 54fffff8 0 0",
               lb_valid, lb_flit, inject_request, pein_flit);
    end
    @(posedge clk);
    #1;
    pe_valid     = 1'b0;
    inject_grant = 1'b1;
    n_cmp++;
    if (lb_valid !== 1'b1 || lb_flit !== 32'h54FF_FFF8) begin
      n_bad++;
      $display("FAIL lb_stall: v %b flit %h want 1 54fffff8", lb_valid, lb_flit);
    end
    @(posedge clk);
    #1;
    inject_grant = 1'b0;
    n_cmp++;
    if (lb_valid !== 1'b1 || lb_flit !== 32'h54FF_FFF8 || inject_request !== 1'b0) begin
      n_bad++;
      $display("FAIL lb_grant_ignored: v %b flit %h req %b want 1 54fffff8 0",
               lb_valid, lb_flit, inject_request);
    end
    lb_ready = 1'b1;
    @(posedge clk);
    #1;
    lb_ready = 1'b0;
    n_cmp++;
    if (lb_valid !== 1'b0 || lb_flit !== 32'h0
        || inject_request !== 1'b1 || pein_flit !== 32'hB000_0000) begin
      n_bad++;
      $display("FAIL lb_to_req: v %b flit %h req %b pein %h want 0 0 1 b0000000",
               lb_valid, lb_flit, inject_request, pein_flit);
    end
    inject_grant = 1'b1;
    @(posedge clk);
    #1;
    inject_grant = 1'b0;
    n_cmp++;
    if (inject_request !== 1'b0 || lb_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL lb_drained: req %b v %b want 0 0", inject_request, lb_valid);
    end
  endtask

  task automatic test_reset_starve();
    logic exp_alarm;
`ifdef CHIPPER_STARVE_MON_EN
    exp_alarm = 1'b1;
`else
    exp_alarm = 1'b0;
`endif
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pe_valid = 1'b1;
      pe_flit  = 32'h0000_2000 + 32'(i);
      @(posedge clk);
      #1;
    end
    pe_valid = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (starve_alarm !== 1'b0 || inject_request !== 1'b1) begin
      n_bad++;
      $display("FAIL starve_15: alarm %b req %b want 0 1", starve_alarm, inject_request);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (starve_alarm !== exp_alarm) begin
      n_bad++;
      $display("FAIL starve_16: alarm %b want %b", starve_alarm, exp_alarm);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (inject_request !== 1'b0 || pein_flit !== 32'h0
        || pe_ready !== 1'b1 || starve_alarm !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_async: req %b pein %h rdy %b alarm %b want 0 0 1 0",
               inject_request, pein_flit, pe_ready, starve_alarm);
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (inject_request !== 1'b0 || lb_valid !== 1'b0 || pe_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_empty: req %b v %b rdy %b want 0 0 1",
               inject_request, lb_valid, pe_ready);
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    rst_n        = 1'b0;
    pe_valid     = 1'b0;
    pe_flit      = '0;
    inject_grant = 1'b0;
    lb_ready     = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_burst();
    test_loopback();
    test_reset_starve();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
